// File: rtl/ofdm_mapper_if.sv
// AXI-Stream style bundle used on both sides of the OFDM constellation mapper.
// The master modport drives data/user/valid/last and receives ready;
// the slave modport is the mirror image.
interface ofdm_mapper_if #(
    parameter int DATA_W = 8,
    parameter int USER_W = 4
);
    logic [DATA_W-1:0] tdata;
    logic [USER_W-1:0] tuser;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output tdata,
        output tuser,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tuser,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/ofdm_mapper.sv
// OFDM constellation mapper sitting right after the 802.11 block interleaver.
// Interleaved coded bytes (bit0 first) are collected in a 16-bit bit buffer
// and turned into one Gray-coded BPSK/QPSK/16-QAM/64-QAM sample per cycle.
// The rate code of the first byte of a packet selects the modulation for the
// whole packet. Output samples are {Q, I}, two's complement Q2.(WIDTH-2).
module ofdm_mapper #(
    parameter int WIDTH = 16
) (
    input  logic          aclk,
    input  logic          aresetn,
    ofdm_mapper_if.slave  s_axis,
    ofdm_mapper_if.master m_axis
);

    // 802.11 SIGNAL-field rate codes
    localparam logic [3:0] RATE_6M  = 4'b1011;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b1010;
    localparam logic [3:0] RATE_18M = 4'b1110;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1101;
    localparam logic [3:0] RATE_48M = 4'b1000;
    localparam logic [3:0] RATE_54M = 4'b1100;

    // Per-modulation scale: round(2^(WIDTH-2) / sqrt(norm)), norm = 1, 2, 10, 42.
    // For WIDTH=16 these come out as 16384, 11585, 5181, 2528.
    localparam real SCALE   = 2.0 ** (WIDTH - 2);
    localparam int  K_BPSK  = $rtoi(SCALE + 0.5);
    localparam int  K_QPSK  = $rtoi(SCALE * 0.7071067811865476 + 0.5);
    localparam int  K_QAM16 = $rtoi(SCALE * 0.31622776601683794 + 0.5);
    localparam int  K_QAM64 = $rtoi(SCALE * 0.1543033499620919 + 0.5);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    typedef enum logic [1:0] {MOD_BPSK, MOD_QPSK, MOD_QAM16, MOD_QAM64} mod_t;

    state_t                 state_q, state_d;
    logic [3:0]             rate_q;
    logic [15:0]            bits_q, bits_d;
    logic [4:0]             cnt_q, cnt_d;
    logic                   alive_q;

    logic [2*WIDTH-1:0]     out_data_q;
    logic [3:0]             out_user_q;
    logic                   out_valid_q;
    logic                   out_last_q;

    mod_t                   mod;
    logic [4:0]             nbpsc;
    logic [4:0]             rem;
    logic                   s_ready;
    logic                   accept;
    logic                   have_sym;
    logic                   load;
    logic                   last_hs;
    logic                   drain_empty;
    logic                   flush;

    int                     lvl_i, lvl_q, k_sel, prod_i, prod_q;
    logic signed [WIDTH-1:0] sym_i, sym_q;

    // Gray-coded 16-QAM axis level from two bits (first bit is the MSB of the label)
    function automatic int lvl16(input logic b_first, input logic b_second);
        case ({b_first, b_second})
            2'b00:   return -3;
            2'b01:   return -1;
            2'b11:   return 1;
            default: return 3;
        endcase
    endfunction

    // Gray-coded 64-QAM axis level from three bits
    function automatic int lvl64(input logic b_a, input logic b_b, input logic b_c);
        case ({b_a, b_b, b_c})
            3'b000:  return -7;
            3'b001:  return -5;
            3'b011:  return -3;
            3'b010:  return -1;
            3'b110:  return 1;
            3'b111:  return 3;
            3'b101:  return 5;
            default: return 7;
        endcase
    endfunction

    // Decode the latched rate into a modulation and coded bits per subcarrier
    always_comb begin
        mod   = MOD_BPSK;
        nbpsc = 5'd1;
        case (rate_q)
            RATE_6M, RATE_9M:   begin mod = MOD_BPSK;  nbpsc = 5'd1; end
            RATE_12M, RATE_18M: begin mod = MOD_QPSK;  nbpsc = 5'd2; end
            RATE_24M, RATE_36M: begin mod = MOD_QAM16; nbpsc = 5'd4; end
            RATE_48M, RATE_54M: begin mod = MOD_QAM64; nbpsc = 5'd6; end
            default:            begin mod = MOD_BPSK;  nbpsc = 5'd1; end
        endcase
    end

    // Handshake and buffer bookkeeping; ready depends only on registers
    assign s_ready     = alive_q && (state_q != DRAIN) && (cnt_q <= 5'd8);
    assign accept      = s_axis.tvalid && s_ready;
    assign have_sym    = (cnt_q >= nbpsc);
    assign load        = (!out_valid_q || m_axis.tready) && have_sym;
    assign rem         = cnt_q - (load ? nbpsc : 5'd0);
    assign last_hs     = out_valid_q && out_last_q && m_axis.tready;
    assign drain_empty = (state_q == DRAIN) && !have_sym && !(out_valid_q && out_last_q);
    assign flush       = last_hs || drain_empty;

    // Consume the low bits for a symbol and append an accepted byte above what remains
    always_comb begin
        bits_d = load ? (bits_q >> nbpsc) : bits_q;
        if (accept) begin
            bits_d = bits_d | ({8'h00, s_axis.tdata} << rem);
        end
        cnt_d = rem + (accept ? 5'd8 : 5'd0);
    end

    // Map the low bits of the buffer to scaled I/Q levels
    always_comb begin
        lvl_i = 0;
        lvl_q = 0;
        k_sel = K_BPSK;
        case (mod)
            MOD_BPSK: begin
                lvl_i = bits_q[0] ? 1 : -1;
                lvl_q = 0;
                k_sel = K_BPSK;
            end
            MOD_QPSK: begin
                lvl_i = bits_q[0] ? 1 : -1;
                lvl_q = bits_q[1] ? 1 : -1;
                k_sel = K_QPSK;
            end
            MOD_QAM16: begin
                lvl_i = lvl16(bits_q[0], bits_q[1]);
                lvl_q = lvl16(bits_q[2], bits_q[3]);
                k_sel = K_QAM16;
            end
            MOD_QAM64: begin
                lvl_i = lvl64(bits_q[0], bits_q[1], bits_q[2]);
                lvl_q = lvl64(bits_q[3], bits_q[4], bits_q[5]);
                k_sel = K_QAM64;
            end
            default: begin
                lvl_i = 0;
                lvl_q = 0;
                k_sel = K_BPSK;
            end
        endcase
        prod_i = lvl_i * k_sel;
        prod_q = lvl_q * k_sel;
    end

    assign sym_i = prod_i[WIDTH-1:0];
    assign sym_q = prod_q[WIDTH-1:0];

    // Packet FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = s_axis.tlast ? DRAIN : RUN;
            RUN:     if (accept && s_axis.tlast) state_d = DRAIN;
            DRAIN:   if (flush) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Packet FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bit buffer, rate latch and the out-of-reset flag that gates ready
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            bits_q  <= '0;
            cnt_q   <= '0;
            rate_q  <= RATE_6M;
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (flush) begin
                bits_q <= '0;
                cnt_q  <= '0;
            end else begin
                bits_q <= bits_d;
                cnt_q  <= cnt_d;
            end
            if (accept && (state_q == IDLE)) begin
                rate_q <= s_axis.tuser;
            end
        end
    end

    // Output register: load a new sample when free, otherwise hold it stable
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_data_q  <= '0;
            out_user_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (load) begin
            out_data_q  <= {sym_q, sym_i};
            out_user_q  <= rate_q;
            out_valid_q <= 1'b1;
            out_last_q  <= (state_q == DRAIN) && (rem < nbpsc);
        end else if (m_axis.tready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = out_data_q;
    assign m_axis.tuser  = out_user_q;
    assign m_axis.tvalid = out_valid_q;
    assign m_axis.tlast  = out_last_q;

endmodule

// File: tb/tb_ofdm_mapper.sv
// Directed testbench for ofdm_mapper: hand-computed constellation points,
// tlast placement, tuser latching, output back-pressure and reset behaviour.
module tb_ofdm_mapper;

    localparam logic [3:0] RATE_6M  = 4'b1011;
    localparam logic [3:0] RATE_12M = 4'b1010;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_54M = 4'b1100;

    logic aclk;
    logic aresetn;

    ofdm_mapper_if #(.DATA_W(8),  .USER_W(4)) s_bus ();
    ofdm_mapper_if #(.DATA_W(32), .USER_W(4)) m_bus ();

    ofdm_mapper #(.WIDTH(16)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_axis  (s_bus.slave),
        .m_axis  (m_bus.master)
    );

    int          vec_count;
    int          miscompares;
    int          stalls;
    logic [7:0]  tx_bytes[$];
    logic [31:0] exp_data[$];
    logic [31:0] got_data[$];
    logic [3:0]  got_user[$];
    logic        got_last[$];

    // Free-running clock
    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    function automatic logic [31:0] pack(input int i_val, input int q_val);
        logic [31:0] iv;
        logic [31:0] qv;
        iv = i_val;
        qv = q_val;
        return {qv[15:0], iv[15:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one packet, collect every output handshake until the tlast symbol
    task automatic applyStimulus(input logic [3:0] rate, input logic [3:0] alt_rate,
                                 input int hold_cycles, input logic [31:0] hold_expect);
        int   idx;
        int   cyc;
        logic acc;
        logic done;
        got_data.delete();
        got_user.delete();
        got_last.delete();
        stalls = 0;
        idx    = 0;
        cyc    = 0;
        done   = 1'b0;
        s_bus.tvalid = 1'b1;
        s_bus.tdata  = tx_bytes[0];
        s_bus.tuser  = rate;
        s_bus.tlast  = (tx_bytes.size() == 1);
        m_bus.tready = (hold_cycles == 0);
        while (!done && cyc < 300) begin
            @(negedge aclk);
            acc = s_bus.tvalid && s_bus.tready;
            if (s_bus.tvalid && !s_bus.tready) stalls++;
            if (!m_bus.tready && m_bus.tvalid) begin
                checkOutput("hold_stable", m_bus.tdata, hold_expect);
            end
            if (m_bus.tvalid && m_bus.tready) begin
                got_data.push_back(m_bus.tdata);
                got_user.push_back(m_bus.tuser);
                got_last.push_back(m_bus.tlast);
                if (m_bus.tlast) done = 1'b1;
            end
            @(posedge aclk);
            #1;
            cyc++;
            if (acc) begin
                idx++;
                if (idx < tx_bytes.size()) begin
                    s_bus.tdata = tx_bytes[idx];
                    s_bus.tuser = alt_rate;
                    s_bus.tlast = (idx == tx_bytes.size() - 1);
                end else begin
                    s_bus.tvalid = 1'b0;
                    s_bus.tdata  = 8'h00;
                    s_bus.tlast  = 1'b0;
                end
            end
            m_bus.tready = (cyc >= hold_cycles);
        end
        checkOutput("packet_done", {31'b0, done}, 32'd1);
        s_bus.tvalid = 1'b0;
    endtask

    // Compare the collected symbols against the expected list
    task automatic checkPacket(input string name, input logic [3:0] rate);
        int n;
        n = exp_data.size();
        checkOutput($sformatf("%s_count", name), got_data.size(), n);
        for (int k = 0; k < n && k < got_data.size(); k++) begin
            checkOutput($sformatf("%s_data%0d", name, k), got_data[k], exp_data[k]);
            checkOutput($sformatf("%s_user%0d", name, k), {28'b0, got_user[k]}, {28'b0, rate});
            checkOutput($sformatf("%s_last%0d", name, k), {31'b0, got_last[k]}, (k == n - 1) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        vec_count    = 0;
        miscompares  = 0;
        aresetn      = 1'b0;
        s_bus.tvalid = 1'b0;
        s_bus.tdata  = 8'h00;
        s_bus.tuser  = 4'h0;
        s_bus.tlast  = 1'b0;
        m_bus.tready = 1'b0;

        // Reset values
        #1;
        checkOutput("rst_s_tready", {31'b0, s_bus.tready}, 32'd0);
        checkOutput("rst_m_tvalid", {31'b0, m_bus.tvalid}, 32'd0);
        checkOutput("rst_m_tdata",  m_bus.tdata, 32'd0);
        checkOutput("rst_m_tuser",  {28'b0, m_bus.tuser}, 32'd0);
        checkOutput("rst_m_tlast",  {31'b0, m_bus.tlast}, 32'd0);
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        checkOutput("post_rst_s_tready", {31'b0, s_bus.tready}, 32'd1);
        @(posedge aclk);
        #1;

        // 6M BPSK, 0xA5
        tx_bytes = '{8'hA5};
        exp_data.delete();
        exp_data.push_back(pack( 16384, 0));
        exp_data.push_back(pack(-16384, 0));
        exp_data.push_back(pack( 16384, 0));
        exp_data.push_back(pack(-16384, 0));
        exp_data.push_back(pack(-16384, 0));
        exp_data.push_back(pack( 16384, 0));
        exp_data.push_back(pack(-16384, 0));
        exp_data.push_back(pack( 16384, 0));
        applyStimulus(RATE_6M, RATE_6M, 0, 32'd0);
        checkPacket("bpsk", RATE_6M);

        // 24M 16-QAM, 0x6C
        tx_bytes = '{8'h6C};
        exp_data.delete();
        exp_data.push_back(pack(-15543,  5181));
        exp_data.push_back(pack( -5181, 15543));
        applyStimulus(RATE_24M, RATE_24M, 0, 32'd0);
        checkPacket("qam16", RATE_24M);

        // 54M 64-QAM, three zero bytes; input must stall once while the buffer is over 8 bits
        tx_bytes = '{8'h00, 8'h00, 8'h00};
        exp_data.delete();
        repeat (4) exp_data.push_back(pack(-17696, -17696));
        applyStimulus(RATE_54M, RATE_54M, 0, 32'd0);
        checkPacket("qam64", RATE_54M);
        checkOutput("qam64_stalls", stalls, 32'd1);

        // 12M QPSK with output back-pressure for 5 cycles
        tx_bytes = '{8'h01};
        exp_data.delete();
        exp_data.push_back(pack( 11585, -11585));
        repeat (3) exp_data.push_back(pack(-11585, -11585));
        applyStimulus(RATE_12M, RATE_12M, 5, pack(11585, -11585));
        checkPacket("qpsk_hold", RATE_12M);

        // 24M packet whose 2nd byte carries a 54M tag: still 16-QAM, tuser stays 24M
        tx_bytes = '{8'h6C, 8'hA5};
        exp_data.delete();
        exp_data.push_back(pack(-15543,  5181));
        exp_data.push_back(pack( -5181, 15543));
        exp_data.push_back(pack( 15543, 15543));
        exp_data.push_back(pack( -5181, -5181));
        applyStimulus(RATE_24M, RATE_54M, 0, 32'd0);
        checkPacket("tuser_latch", RATE_24M);

        // Reset in the middle of a 54M packet, output stalled
        s_bus.tvalid = 1'b1;
        s_bus.tdata  = 8'hFF;
        s_bus.tuser  = RATE_54M;
        s_bus.tlast  = 1'b0;
        m_bus.tready = 1'b0;
        repeat (4) begin
            @(posedge aclk);
            #1;
        end
        @(negedge aclk);
        checkOutput("pre_rst_tvalid", {31'b0, m_bus.tvalid}, 32'd1);
        checkOutput("pre_rst_tdata",  m_bus.tdata, pack(7584, 7584));
        aresetn = 1'b0;
        #1;
        checkOutput("mid_rst_tvalid", {31'b0, m_bus.tvalid}, 32'd0);
        checkOutput("mid_rst_tdata",  m_bus.tdata, 32'd0);
        checkOutput("mid_rst_s_tready", {31'b0, s_bus.tready}, 32'd0);
        s_bus.tvalid = 1'b0;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Fresh 6M packet after the reset, 0x3C
        tx_bytes = '{8'h3C};
        exp_data.delete();
        exp_data.push_back(pack(-16384, 0));
        exp_data.push_back(pack(-16384, 0));
        exp_data.push_back(pack( 16384, 0));
        exp_data.push_back(pack( 16384, 0));
        exp_data.push_back(pack( 16384, 0));
        exp_data.push_back(pack( 16384, 0));
        exp_data.push_back(pack(-16384, 0));
        exp_data.push_back(pack(-16384, 0));
        applyStimulus(RATE_6M, RATE_6M, 0, 32'd0);
        checkPacket("after_rst", RATE_6M);

        repeat (3) @(posedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
